bnn_seq_neuron: RTL and testbench
=================================

// Module: bnn_seq_neuron
// PURPOSE
//  Parametrised multi-beat binary neuron (XNOR-popcount).
//  - Consumes BEATS input/weight words of IN_W bits over a valid/ready stream.
//  - Accumulates the XNOR popcount across the window, then compares it against a programmable threshold.
//  - Emits one sign bit per window over an output valid/ready handshake.
//  - Building block for BNN layers where fan-in exceeds one input word.
// PARAMETERS
//  IN_W        8                        bits per input/weight beat (>=1)
//  BEATS       4                        beats per neuron window (>=1)
//  THR_DEFAULT (IN_W*BEATS+1)/2         threshold loaded at reset (sign(2*pc-N)>=0 equivalent)
//  localparam ACC_W = $clog2(IN_W*BEATS+1), width of accumulator/threshold
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      global enable; low freezes all state except threshold writes
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  in_data    in   IN_W   binarised activations (1=+1, 0=-1)
//  in_weight  in   IN_W   binarised weights
//  thr_we     in   1      threshold write strobe
//  thr_in     in   ACC_W  new threshold value (unsigned)
//  out_valid  out  1      o_neuron holds a completed result
//  out_ready  in   1      downstream accepts result
//  o_neuron   out  1      neuron output: 1 when window popcount >= threshold
//  busy       out  1      at least one beat of the current window accepted
// BEHAVIOUR
//  - Reset values: state=ACC, acc=0, beat_cnt=0, thr=THR_DEFAULT, out_valid=0, o_neuron=0, busy=0.
//  - Beat accept = in_valid & in_ready & ena. Per beat pc = popcount(~(in_data ^ in_weight)), range 0..IN_W.
//  - FSM ACC:
//    - in_ready = ena.
//    - Accept of a non-final beat: acc += pc, beat_cnt++.
//    - Accept of the final beat (beat_cnt==BEATS-1):
//      - o_neuron <= ((acc+pc) >= thr).
//      - out_valid <= 1; acc and beat_cnt <= 0; go to OUT.
//  - FSM OUT:
//    - in_ready = 0; out_valid and o_neuron held stable.
//    - out_valid & out_ready & ena: out_valid <= 0, go to ACC. in_ready rises the next cycle; no same-cycle turnaround.
//  - Latency: out_valid rises 1 cycle after the final beat is accepted. Peak throughput is 1 result per BEATS+1 cycles.
//  - BEATS=1: every accepted beat completes a window.
//  - busy = (state==ACC) & (beat_cnt!=0).
//  - Arithmetic is unsigned ACC_W bits. Max sum IN_W*BEATS fits by construction, so there is no wrap.
//  - Threshold:
//    - thr_we writes thr <= thr_in regardless of ena or state.
//    - Comparison uses the register value before the edge, so a write coinciding with the final beat applies to the next window.
//    - thr=0 always yields 1; thr > IN_W*BEATS always yields 0.
//  - ena low: no accept, no FSM transition, no output handshake; partial acc retained; outputs held.
//  - in_valid while in OUT, or while ena=0: ignored. The data is not consumed.
//  - Reset asserted mid-window or in OUT: partial sum and pending result discarded; all values return to reset state.
// CONFIGURATION
//  BNN_ACC_OUT_EN defined:
//    - Adds output port acc_out [ACC_W-1:0], registered alongside o_neuron.
//    - Carries the final window popcount (acc+pc), valid while out_valid=1; reset value 0.
//  BNN_ACC_OUT_EN undefined: port and register absent; o_neuron is the only result.
// TESTING (IN_W=8, BEATS=4, THR_DEFAULT=16 unless stated)
//  1 Reset release -> in_ready=1 (ena=1), out_valid=0, o_neuron=0, busy=0, thr=16.
//  2 4 beats data=weight=8'hA5 back-to-back -> out_valid=1 one cycle after 4th; o_neuron=1 (acc 32); acc_out=32 with macro.
//  3 4 beats data=8'hFF weight=8'h00 -> o_neuron=0 (acc 0). Repeat with thr written to 0 -> o_neuron=1.
//    Then pc=4 per beat (acc 16) at thr 16 -> o_neuron=1 (boundary); at thr 17 -> o_neuron=0.
//  4 Result pending, out_ready=0 for 5 cycles, in_valid=1 -> out_valid/o_neuron held, in_ready=0, no beats consumed.
//    Raise out_ready -> handshake; in_ready=1 next cycle.
//  5 ena=0 for 3 cycles after 2 beats, then resume -> result identical to uninterrupted window.
//    thr_we with thr_in=33 on the final-beat cycle -> current result uses 16, next window uses 33 (o_neuron=0).
//  6 rst_n low after 2 beats (pc 8 each), release, then 4 beats pc=2 -> acc 8 < 16, o_neuron=0 (earlier beats discarded).

Source files
------------

// File: rtl/bnn_seq_neuron_if.sv
// Stream, threshold-programming and result signals of the sequential BNN neuron.
// Optional acc_out field is present only when BNN_ACC_OUT_EN is defined.
interface bnn_seq_neuron_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned BEATS = 4
);
    localparam int unsigned ACC_W = $clog2(IN_W * BEATS + 1);

    logic             ena;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  in_weight;
    logic             thr_we;
    logic [ACC_W-1:0] thr_in;
    logic             out_valid;
    logic             out_ready;
    logic             o_neuron;
    logic             busy;
`ifdef BNN_ACC_OUT_EN
    logic [ACC_W-1:0] acc_out;

    modport master (
        output ena, in_valid, in_data, in_weight, thr_we, thr_in, out_ready,
        input  in_ready, out_valid, o_neuron, busy, acc_out
    );
    modport slave (
        input  ena, in_valid, in_data, in_weight, thr_we, thr_in, out_ready,
        output in_ready, out_valid, o_neuron, busy, acc_out
    );
`else
    modport master (
        output ena, in_valid, in_data, in_weight, thr_we, thr_in, out_ready,
        input  in_ready, out_valid, o_neuron, busy
    );
    modport slave (
        input  ena, in_valid, in_data, in_weight, thr_we, thr_in, out_ready,
        output in_ready, out_valid, o_neuron, busy
    );
`endif
endinterface

// File: rtl/bnn_seq_neuron.sv
// Multi-beat XNOR-popcount binary neuron with programmable threshold.
// Define BNN_ACC_OUT_EN to also export the final window popcount on acc_out.
module bnn_seq_neuron #(
    parameter int unsigned IN_W        = 8,
    parameter int unsigned BEATS       = 4,
    parameter int unsigned THR_DEFAULT = (IN_W * BEATS + 1) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    bnn_seq_neuron_if.slave  bus
);
    localparam int unsigned ACC_W = $clog2(IN_W * BEATS + 1);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PC_W  = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_neuron, w_neuron_nxt;
    logic [ACC_W-1:0] r_thr;
    logic [IN_W-1:0]  w_xnor;
    logic [PC_W-1:0]  w_pc;
    logic [ACC_W-1:0] w_sum;
    logic             w_in_ready;
    logic             w_accept;
`ifdef BNN_ACC_OUT_EN
    logic [ACC_W-1:0] r_acc_out, w_acc_out_nxt;
`endif

    // Per-beat agreement count between activations and weights.
    always_comb begin
        w_xnor = ~(bus.in_data ^ bus.in_weight);
        w_pc   = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_pc = w_pc + PC_W'(w_xnor[i]);
        end
    end

    assign w_sum      = r_acc + ACC_W'(w_pc);
    assign w_in_ready = bus.ena & (r_state == ST_ACC);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
        w_neuron_nxt    = r_neuron;
`ifdef BNN_ACC_OUT_EN
        w_acc_out_nxt   = r_acc_out;
`endif
        case (r_state)
            ST_ACC: begin
                if (w_accept) begin
                    if (r_cnt == LAST_BEAT) begin
                        // Threshold sampled pre-edge: a same-cycle write affects the next window only.
                        w_neuron_nxt    = (w_sum >= r_thr);
                        w_out_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_OUT;
`ifdef BNN_ACC_OUT_EN
                        w_acc_out_nxt   = w_sum;
`endif
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (r_out_valid & bus.out_ready & bus.ena) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_ACC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_neuron    <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_neuron    <= w_neuron_nxt;
        end
    end

`ifdef BNN_ACC_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_acc_out <= '0;
        else        r_acc_out <= w_acc_out_nxt;
    end

    assign bus.acc_out = r_acc_out;
`endif

    // Threshold writes bypass ena and the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_thr <= ACC_W'(THR_DEFAULT);
        else if (bus.thr_we) r_thr <= bus.thr_in;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.o_neuron  = r_neuron;
    assign bus.busy      = (r_state == ST_ACC) & (r_cnt != '0);
endmodule

// File: tb/tb_bnn_seq_neuron.sv
// Directed plus randomized bench for bnn_seq_neuron (IN_W=8, BEATS=4).
// Reference: running sum of per-beat agreement counts compared against a modelled threshold.
module tb_bnn_seq_neuron;
    localparam int unsigned IN_W  = 8;
    localparam int unsigned BEATS = 4;
    localparam int THR_DEF = (IN_W * BEATS + 1) / 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   m_sum;
    int   m_thr;

    bnn_seq_neuron_if #(.IN_W(IN_W), .BEATS(BEATS)) bus ();

    bnn_seq_neuron #(.IN_W(IN_W), .BEATS(BEATS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; the model accumulates agreement count from the operands.
    task automatic beat(input logic [7:0] d, input logic [7:0] w);
        logic [7:0] agree;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_weight = w;
        tick();
        agree = ~(d ^ w);
        m_sum += $countones(agree);
        bus.in_valid = 1'b0;
    endtask

    task automatic window4(input logic [7:0] d, input logic [7:0] w);
        for (int i = 0; i < BEATS; i++) beat(d, w);
    endtask

    task automatic expect_result(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_neuron"}, 32'(bus.o_neuron), 32'(m_sum >= m_thr));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
`ifdef BNN_ACC_OUT_EN
        chk({tag, "_acc_out"}, 32'(bus.acc_out), 32'(m_sum));
`endif
        m_sum = 0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_hs_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic write_thr(input int v);
        bus.thr_we = 1'b1;
        bus.thr_in = 6'(v);
        tick();
        bus.thr_we = 1'b0;
        m_thr = v;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        m_sum = 0;
        m_thr = THR_DEF;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_weight = '0;
        bus.thr_we = 1'b0;
        bus.thr_in = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_neuron", 32'(bus.o_neuron), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef BNN_ACC_OUT_EN
        chk("rst_acc_out", 32'(bus.acc_out), 32'd0);
`endif

        // Full agreement window.
        beat(8'hA5, 8'hA5);
        chk("busy_after_1", 32'(bus.busy), 32'd1);
        beat(8'hA5, 8'hA5);
        beat(8'hA5, 8'hA5);
        beat(8'hA5, 8'hA5);
        chk("a5_sum_is_32", 32'(m_sum), 32'd32);
        expect_result("a5");
        chk("a5_busy", 32'(bus.busy), 32'd0);
        handshake("a5");

        // Zero agreement, then threshold edge cases.
        window4(8'hFF, 8'h00);
        expect_result("zero_thr16");
        handshake("zero_thr16");
        write_thr(0);
        window4(8'hFF, 8'h00);
        expect_result("zero_thr0");
        handshake("zero_thr0");
        write_thr(16);
        window4(8'h0F, 8'h00);
        chk("bnd_neuron_eq", 32'(bus.o_neuron), 32'd1);
        expect_result("bnd_thr16");
        handshake("bnd_thr16");
        write_thr(17);
        window4(8'h0F, 8'h00);
        chk("bnd_neuron_lt", 32'(bus.o_neuron), 32'd0);
        expect_result("bnd_thr17");
        handshake("bnd_thr17");
        write_thr(16);

        // Backpressure: result held, incoming beats ignored.
        window4(8'hA5, 8'h5A);
        begin
            logic exp_n;
            exp_n = (m_sum >= m_thr);
            expect_result("bp");
            bus.in_valid = 1'b1;
            bus.in_data = 8'hFF;
            bus.in_weight = 8'hFF;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
                chk("bp_hold_neuron", 32'(bus.o_neuron), 32'(exp_n));
                chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.in_valid = 1'b0;
        end
        handshake("bp");
        chk("bp_no_consume", 32'(bus.busy), 32'd0);

        // ena stall mid-window gives the uninterrupted result.
        beat(8'h3C, 8'h0F);
        beat(8'h3C, 8'h0F);
        bus.ena = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h00;
        bus.in_weight = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_busy", 32'(bus.busy), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.ena = 1'b1;
        beat(8'h3C, 8'h0F);
        // Threshold write coincides with the final beat: old threshold applies.
        bus.thr_we = 1'b1;
        bus.thr_in = 6'd33;
        beat(8'h3C, 8'h0F);
        bus.thr_we = 1'b0;
        expect_result("stall");
        m_thr = 33;
        bus.ena = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("ena_out_hold", 32'(bus.out_valid), 32'd1);
        bus.ena = 1'b1;
        bus.out_ready = 1'b0;
        handshake("stall");
        window4(8'hA5, 8'hA5);
        chk("thr33_neuron", 32'(bus.o_neuron), 32'd0);
        expect_result("thr33");
        handshake("thr33");

        // Reset mid-window discards partial sum and restores default threshold.
        beat(8'hA5, 8'hA5);
        beat(8'hA5, 8'hA5);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        #1 rst_n = 1'b1;
        m_sum = 0;
        m_thr = THR_DEF;
        window4(8'h3F, 8'h00);
        chk("mrst_sum_8", 32'(m_sum), 32'd8);
        chk("mrst_neuron", 32'(bus.o_neuron), 32'd0);
        expect_result("mrst");
        handshake("mrst");

        // Randomized windows with thresholds, enable gaps and output stalls.
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) write_thr(int'($urandom_range(0, 33)));
            for (int b = 0; b < BEATS; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.ena = 1'b0;
                    bus.in_valid = 1'b1;
                    repeat ($urandom_range(1, 2)) tick();
                    bus.ena = 1'b1;
                    bus.in_valid = 1'b0;
                end
                beat(8'($urandom), 8'($urandom));
            end
            expect_result("rnd");
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_hold", 32'(bus.out_valid), 32'd1);
            handshake("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
